// File: rtl/byte_bank_reader_pkg.sv
// Shared types and constants for the byte bank reader.
package byte_bank_reader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_bank_reader_select.sv
// Combinational DEPTH-to-1 byte mux over the flattened bank.
module byte_select
  import byte_bank_reader_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH*BYTE_W-1:0] bank,
  input  logic [ADDR_W-1:0]       addr,
  output logic [BYTE_W-1:0]       data
);

  assign data = bank[int'(addr)*BYTE_W +: BYTE_W];

endmodule

// File: rtl/byte_bank_reader.sv
// Streams a window of bytes from the bank over valid/ready, then pulses done.
// Optional even-parity output enabled by BYTE_BANK_READER_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for start; start_addr/count sampled here
// READ  | out_data valid, advancing on each handshake
// DONE  | one-cycle done pulse, then back to IDLE
module byte_bank_reader
  import byte_bank_reader_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DEPTH*BYTE_W-1:0] bank,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W:0]         count,
  output logic                    busy,
  output logic [BYTE_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    done
`ifdef BYTE_BANK_READER_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("byte_bank_reader: DEPTH must be a power of two and at least 2");
  end

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   load_count;
  logic [BYTE_W-1:0]  sel_byte;
  logic               handshake;
  logic               last_beat;
  logic               first_load;
  logic               load_byte;

  assign load_count = (count > DEPTH_CNT) ? DEPTH_CNT : count;
  assign handshake  = out_valid & out_ready;
  assign last_beat  = (remaining == CNT_W'(1));
  assign first_load = (state == IDLE) && start && (load_count != '0);
  assign load_byte  = first_load || ((state == READ) && handshake && !last_beat);

  // In IDLE the mux looks at the requested start byte; in READ it prefetches the next one.
  assign sel_addr = (state == IDLE) ? start_addr : addr + ADDR_W'(1);

  byte_select #(
    .DEPTH (DEPTH)
  ) u_byte_select (
    .bank (bank),
    .addr (sel_addr),
    .data (sel_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
      addr      <= '0;
      remaining <= '0;
    end else begin
      if (load_byte) begin
        out_data <= sel_byte;
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= load_count;
            busy      <= 1'b1;
            if (load_count != '0) begin
              out_valid <= 1'b1;
              state     <= READ;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        READ: begin
          if (handshake) begin
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (last_beat) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BYTE_BANK_READER_PARITY_EN
  // Loaded on the same condition as out_data so the two never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (load_byte) begin
      out_parity <= even_parity(sel_byte);
    end
  end
`endif

endmodule

// File: tb/tb_byte_bank_reader.sv
// Self-checking bench for byte_bank_reader: directed scenarios plus randomized transfers.
module tb_byte_bank_reader;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DEPTH*8-1:0] bank;
  logic             start;
  logic [2:0]       start_addr;
  logic [3:0]       count;
  logic             busy;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             done;
`ifdef BYTE_BANK_READER_PARITY_EN
  logic             out_parity;
`endif

  byte_bank_reader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank       (bank),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .done       (done)
`ifdef BYTE_BANK_READER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int vld_cnt, done_cnt;
  logic [7:0] beats[$];

  // transaction-level reference: what the consumer should see
  bit         m_valid, m_busy, m_done;
  int         m_left, m_idx;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] bbyte(input int idx);
    return bank[8*idx +: 8];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_done = 0; m_left = 0; m_idx = 0; m_data = 8'h00;
  endtask

  task automatic model_step();
    int n;
    if (!rst_n) begin
      model_reset();
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_left--;
        m_idx = (m_idx + 1) % DEPTH;
        if (m_left == 0) begin
          m_valid = 0;
          m_done  = 1;
        end else begin
          m_data = bbyte(m_idx);
        end
      end
    end else if (start) begin
      n = (int'(count) > DEPTH) ? DEPTH : int'(count);
      m_busy = 1;
      if (n == 0) begin
        m_done = 1;
      end else begin
        m_left  = n;
        m_idx   = int'(start_addr);
        m_valid = 1;
        m_data  = bbyte(m_idx);
      end
    end
  endtask

  task automatic tick();
    model_step();
    if (out_valid && out_ready) beats.push_back(out_data);
    @(posedge clk);
    #1;
    chk("valid", out_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (m_valid) chk("data", out_data, m_data);
`ifdef BYTE_BANK_READER_PARITY_EN
    chk("parity", out_parity, ^m_data);
`endif
    vld_cnt  += int'(out_valid);
    done_cnt += int'(done);
  endtask

  function automatic logic rdy(input int mode);
    return (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endfunction

  task automatic begin_xfer(input int a, input int c, input logic r);
    beats.delete();
    vld_cnt = 0; done_cnt = 0;
    start = 1'b1; start_addr = 3'(a); count = 4'(c); out_ready = r;
    tick();
    start = 1'b0;
  endtask

  // mode 1: ready held high; mode 2: random ready, start noise and bank churn
  task automatic drain(input int mode, input int max_cyc);
    int n = 0;
    while (m_busy && n < max_cyc) begin
      out_ready = rdy(mode);
      if (mode == 2) begin
        start      = ($urandom_range(0, 3) == 0);
        start_addr = 3'($urandom);
        count      = 4'($urandom);
        if ($urandom_range(0, 3) == 0) bank[8*$urandom_range(0, DEPTH-1) +: 8] = 8'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("xfer_timeout", 32'(n < max_cyc), 32'd1);
    tick();
    chk("idle_busy", busy, 1'b0);
  endtask

  task automatic exp_beats(input string tag, input int a, input int n);
    chk({tag, "_nbeats"}, beats.size(), n);
    for (int k = 0; k < n && k < beats.size(); k++)
      chk({tag, "_beat"}, beats[k], (a + k) % DEPTH);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < DEPTH; i++) bank[8*i +: 8] = 8'(i);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b0;
    fill_identity();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", out_data, 8'h00);
    rst_n = 1'b1;
    tick();

    // basic read
    begin_xfer(2, 3, 1'b1);
    drain(1, 50);
    exp_beats("basic", 2, 3);
    chk("basic_vld_cycles", vld_cnt, 3);
    chk("basic_done_cnt", done_cnt, 1);

    // wrap-around
    begin_xfer(6, 4, 1'b1);
    drain(1, 50);
    exp_beats("wrap", 6, 4);

    // back-pressure with bank change under a stalled beat
    begin_xfer(2, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bank[8*2 +: 8] = 8'hA0 + 8'(i);
      tick();
      chk("bp_hold_data", out_data, 8'h02);
      chk("bp_hold_valid", out_valid, 1'b1);
    end
    drain(1, 50);
    fill_identity();
    exp_beats("bp", 2, 3);

    // empty transfer
    begin_xfer(3, 0, 1'b1);
    chk("empty_done", done, 1'b1);
    chk("empty_busy", busy, 1'b1);
    drain(1, 50);
    chk("empty_vld_cycles", vld_cnt, 0);
    chk("empty_done_cnt", done_cnt, 1);

    // clamp 12 -> 8
    begin_xfer(0, 12, 1'b1);
    drain(1, 50);
    exp_beats("clamp", 0, 8);
    chk("clamp_vld_cycles", vld_cnt, 8);

    // start during READ is ignored
    begin_xfer(6, 4, 1'b1);
    tick();
    start = 1'b1; start_addr = 3'd0; count = 4'd8;
    tick();
    start = 1'b0;
    drain(1, 50);
    exp_beats("ignored", 6, 4);
    chk("ignored_vld_cycles", vld_cnt, 4);

    // asynchronous reset mid-transfer
    begin_xfer(0, 4, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_data", out_data, 8'h00);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    begin_xfer(5, 2, 1'b1);
    drain(1, 50);
    exp_beats("post_rst", 5, 2);

`ifdef BYTE_BANK_READER_PARITY_EN
    bank[8*0 +: 8] = 8'hB3;
    bank[8*1 +: 8] = 8'h03;
    begin_xfer(0, 2, 1'b1);
    chk("parity_b3", out_parity, 1'b1);
    tick();
    chk("parity_03", out_parity, 1'b0);
    drain(1, 50);
    fill_identity();
`endif

    // randomized transfers
    for (int t = 0; t < 120; t++) begin
      for (int i = 0; i < DEPTH; i++) bank[8*i +: 8] = 8'($urandom);
      begin_xfer($urandom_range(0, DEPTH-1), $urandom_range(0, 15), rdy(2));
      drain(2, 200);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
